muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use reset rst (synchronous, active-high) and clock clk.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-004 md_op  in  3  operation request valid this cycle: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-005 a  in  32  operand rs (dividend / multiplicand / MT source).
REQ-006 b  in  32  operand rt (divisor / multiplier).
REQ-007 hi  out  32  architectural HI register.
REQ-008 lo  out  32  architectural LO register.
REQ-009 busy  out  1  registered; high while a MULT/DIV is in flight.
REQ-010 stall_req  out  1  combinational: busy OR (md_op in 1..4); consumed by hazard unit to hold mf/mt/md instructions in D.

Function
REQ-011 Start: on a rising edge with busy=0 and md_op in 1..4, the block SHALL latch op, a, b, load cycle counter with N (N=5 for MULT/MULTU, N=10 for DIV/DIVU) and set busy=1.
REQ-012 busy SHALL stay high for exactly N cycles after the start edge; counter decrements once per edge; on the edge where counter goes 1->0, busy SHALL fall and hi/lo SHALL update in that same edge.
REQ-013 hi/lo SHALL hold previous values throughout the busy window; intermediate results SHALL NOT be visible.
REQ-014 MULT: {hi,lo} = signed(a) * signed(b), 64-bit product; MULTU: unsigned 64-bit product.
REQ-015 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-016 DIVU: lo = unsigned quotient, hi = unsigned remainder.
REQ-017 Divide by zero (b=0, DIV or DIVU): busy timing unchanged (10 cycles); hi and lo SHALL remain unchanged at completion.
REQ-018 MTHI/MTLO with busy=0: hi (resp. lo) <= a on that edge; busy stays 0; other register unchanged.
REQ-019 Any md_op != NONE sampled while busy=1 SHALL be ignored (no state change); a bench assertion flags it as upstream protocol violation.
REQ-020 Back-to-back: a start is accepted on the edge immediately following the completion edge (busy=0 then); no bubble beyond that.
REQ-021 Operand capture: a/b changes after the start edge SHALL NOT affect the result.
REQ-022 stall_req SHALL be high in the start cycle itself (before busy rises) and for every busy cycle.

Reset
REQ-023 On rst: hi=0, lo=0, busy=0, counter=0, latched op=NONE; all outputs valid the cycle after.
REQ-024 rst during a busy window SHALL abort the operation; result discarded, hi/lo=0, no late write.
REQ-025 rst SHALL take priority over simultaneous md_op.

Verification
REQ-026 MULT a=0xFFFFFFFF b=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
REQ-027 MULTU a=0xFFFFFFFF b=0x00000002 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
REQ-028 DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1.
REQ-029 MTHI a=0x12345678, then DIVU a=7 b=0 -> hi stays 0x12345678, lo unchanged, busy falls after 10 cycles.
REQ-030 MULT started, MTLO a=0xAAAA issued at busy cycle 2, rst at busy cycle 3 -> MTLO ignored, hi=lo=0, busy=0, no write at cycle 5.
REQ-031 MULTU 3*4 completes, next-cycle DIVU 9/4 accepted immediately -> hi/lo=0/12 after 5 cycles, then hi=1 lo=2 after 10 more; stall_req continuous.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency MULT/DIV with MTHI/MTLO,
// results committed to HI/LO only on the completion edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(5);
  localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(10);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, hi_d, lo_d;
  logic             md_req;
  logic [2*W-1:0]   prod_s, prod_u;
  logic [W-1:0]     a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [W-1:0]     res_hi, res_lo;
  logic             is_sdiv, res_write;

  assign md_req    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign busy      = (state_q == S_BUSY);
  assign stall_req = busy | md_req;

  // Result datapath on latched operands; signed divide via magnitudes so
  // 0x80000000 / -1 wraps to 0x80000000 without a special case.
  always_comb begin
    prod_s  = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    prod_u  = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    is_sdiv = (op_q == OP_DIV);
    a_mag   = (is_sdiv && a_q[W-1]) ? -a_q : a_q;
    b_mag   = (is_sdiv && b_q[W-1]) ? -b_q : b_q;
    q_mag   = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag   = (b_mag == '0) ? '0 : a_mag % b_mag;
    quo     = (is_sdiv && (a_q[W-1] ^ b_q[W-1])) ? -q_mag : q_mag;
    rem     = (is_sdiv && a_q[W-1]) ? -r_mag : r_mag;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      default:  {res_hi, res_lo} = {rem, quo};
    endcase
    res_write = (op_q == OP_MULT) || (op_q == OP_MULTU) || (b_q != '0);
  end

  // Next-state: requests are only honoured while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi;
    lo_d    = lo;
    case (state_q)
      S_IDLE: begin
        if (md_req) begin
          state_d = S_BUSY;
          op_d    = md_op;
          a_d     = a;
          b_d     = b;
          cnt_d   = (md_op <= OP_MULTU) ? MUL_CYCLES : DIV_CYCLES;
        end else if (md_op == OP_MTHI) begin
          hi_d = a;
        end else if (md_op == OP_MTLO) begin
          lo_d = a;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          op_d    = OP_NONE;
          if (res_write) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

endmodule
